aes_round_iter: RTL and testbench

AES_ROUND_ITER -- requirements
Module: aes_round_iter

---
 rtl/aes_round_iter.sv | 247 ++++++++++++++++++++++++
 tb/tb_aes_round_iter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_iter.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_iter
//  Purpose  : Iterative AES encryption core. One block is processed at a
//             time; COLS state columns are transformed per clock, so a round
//             takes 4/COLS cycles. Round keys come from an external key
//             schedule that is indexed by round_idx and answers in the same
//             cycle.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NR    : number of rounds (10, 12 or 14)
//    COLS  : state columns processed per cycle (1, 2 or 4)
//  Ports
//    clk        in   clock, rising edge
//    rst        in   asynchronous reset, active high
//    vin        in   input block valid
//    rdy        out  a block is accepted this cycle if vin is high
//    state_in   in   128-bit plaintext, byte in0 in bits [127:120]
//    round_idx  out  index of the round key needed this cycle
//    round_key  in   round key for round_idx (same-cycle)
//    state_out  out  128-bit ciphertext, held until the next block finishes
//    vout       out  one-cycle pulse, high in the DONE cycle
//    busy       out  rounds are being computed
//    abort      in   only with AES_ROUND_ITER_ABORT_EN: drop the block in
//                    flight (ROUND or DONE) and return to IDLE
//  Build option
//    AES_ROUND_ITER_ABORT_EN : adds the abort input
//  Timing
//    vout is high during the DONE cycle; state_out is registered on the edge
//    that closes that cycle. Latency is 1 + NR*(4/COLS) cycles from the accept
//    edge to the edge that ends the vout cycle.
// ============================================================================
module aes_round_iter #(
  parameter int NR   = 10,
  parameter int COLS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vin,
  output logic         rdy,
  input  logic [127:0] state_in,
  output logic [3:0]   round_idx,
  input  logic [127:0] round_key,
  output logic [127:0] state_out,
  output logic         vout,
  output logic         busy
`ifdef AES_ROUND_ITER_ABORT_EN
  ,
  input  logic         abort
`endif
);

  // Column counter wraps after the last column group of a round.
  localparam logic [1:0] C_LAST_COL = 2'(4 / COLS - 1);
  localparam logic [3:0] C_NR       = 4'(NR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_work;
  logic [127:0] r_snap;
  logic [3:0]   r_rnd;
  logic [1:0]   r_colcnt;

  logic         w_wrap;
  logic         w_last;
  logic         w_abort;
  logic [127:0] w_init;
  logic [127:0] w_work_upd;
  logic [31:0]  w_col_res [COLS];
  logic [1:0]   w_col_idx [COLS];

  // --------------------------------------------------------------------------
  // GF(2^8) arithmetic, polynomial 0x11B
  // --------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed rather than tabulated: inverse as a^254 (0 maps to 0),
  // followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] base;
    inv  = 8'h01;
    base = a;
    // 254 = 0b1111_1110: accumulate a^2, a^4, ... a^128
    for (int i = 1; i < 8; i++) begin
      base = gf_mul(base, base);
      inv  = gf_mul(inv, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // One output column of a round: ShiftRows (row r of column c comes from
  // column c+r), SubBytes, then MixColumns unless this is the final round.
  function automatic logic [31:0] col_round(input logic [127:0] s,
                                            input logic [1:0]   c,
                                            input logic         last);
    logic [7:0] a [4];
    logic [7:0] b [4];
    logic [1:0] src;
    for (int r = 0; r < 4; r++) begin
      src  = c + 2'(r);
      a[r] = sbox(s[127 - 8 * (4 * int'(src) + r) -: 8]);
    end
    if (last) begin
      for (int r = 0; r < 4; r++) b[r] = a[r];
    end else begin
      b[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
      b[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
      b[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
      b[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  assign w_wrap = (r_colcnt == C_LAST_COL);
  assign w_last = (r_rnd == C_NR);
  assign w_init = state_in ^ round_key;

`ifdef AES_ROUND_ITER_ABORT_EN
  assign w_abort = abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  generate
    for (genvar j = 0; j < COLS; j++) begin : g_col
      assign w_col_idx[j] = 2'(int'(r_colcnt) * COLS + j);
      assign w_col_res[j] = col_round(r_snap, w_col_idx[j], w_last) ^
                            round_key[127 - 32 * int'(w_col_idx[j]) -: 32];
    end
  endgenerate

  // Work register with this cycle's columns replaced.
  always_comb begin
    w_work_upd = r_work;
    for (int j = 0; j < COLS; j++) begin
      w_work_upd[127 - 32 * int'(w_col_idx[j]) -: 32] = w_col_res[j];
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    rdy         = 1'b0;
    busy        = 1'b0;
    vout        = 1'b0;
    round_idx   = 4'd0;
    case (r_state)
      IDLE: begin
        rdy = 1'b1;
        if (vin) w_state_nxt = ROUND;
      end
      ROUND: begin
        busy      = 1'b1;
        round_idx = r_rnd;
        if (w_wrap && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        vout        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // An honoured abort suppresses the result, including in DONE.
    if (w_abort) begin
      w_state_nxt = IDLE;
      vout        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work    <= '0;
      r_snap    <= '0;
      r_rnd     <= 4'd0;
      r_colcnt  <= 2'd0;
      state_out <= '0;
    end else if (w_abort) begin
      r_rnd    <= 4'd0;
      r_colcnt <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (vin) begin
            // Initial AddRoundKey; the snapshot starts equal to the work
            // register so round 1 reads a complete state.
            r_work   <= w_init;
            r_snap   <= w_init;
            r_rnd    <= 4'd1;
            r_colcnt <= 2'd0;
          end
        end
        ROUND: begin
          r_work <= w_work_upd;
          if (w_wrap) begin
            r_colcnt <= 2'd0;
            r_rnd    <= r_rnd + 4'd1;
            r_snap   <= w_work_upd;
          end else begin
            r_colcnt <= r_colcnt + 2'd1;
          end
        end
        DONE: begin
          state_out <= r_work;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_round_iter
//  Purpose  : Self-checking bench for aes_round_iter. Three instances cover
//             NR=10/COLS=1, NR=10/COLS=4 and NR=14/COLS=2. Round keys come
//             from a key-expansion model indexed by each instance's round_idx.
//             Abort checks are built when AES_ROUND_ITER_ABORT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_round_iter;

  localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CC3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vin;
  logic [127:0] sin;
  int cur;

  logic vin_a, rdy_a, vout_a, busy_a;
  logic vin_b, rdy_b, vout_b, busy_b;
  logic vin_c, rdy_c, vout_c, busy_c;
  logic [3:0] ridx_a, ridx_b, ridx_c;
  logic [127:0] rk_a, rk_b, rk_c, sout_a, sout_b, sout_c;
  logic [127:0] keys_a [16];
  logic [127:0] keys_b [16];
  logic [127:0] keys_c [16];
  logic [7:0] tb_sbox [256];

  logic s_rdy, s_busy, s_vout;
  logic [127:0] s_sout;

  int n_tests = 0;
  int n_fail  = 0;
  int vcount_a = 0;

`ifdef AES_ROUND_ITER_ABORT_EN
  logic abort_a;
`endif

  always #5 clk = ~clk;

  assign vin_a = vin && (cur == 0);
  assign vin_b = vin && (cur == 1);
  assign vin_c = vin && (cur == 2);
  assign rk_a  = keys_a[ridx_a];
  assign rk_b  = keys_b[ridx_b];
  assign rk_c  = keys_c[ridx_c];

  always_comb begin
    case (cur)
      1: begin s_rdy = rdy_b; s_busy = busy_b; s_vout = vout_b; s_sout = sout_b; end
      2: begin s_rdy = rdy_c; s_busy = busy_c; s_vout = vout_c; s_sout = sout_c; end
      default: begin s_rdy = rdy_a; s_busy = busy_a; s_vout = vout_a; s_sout = sout_a; end
    endcase
  end

  always @(negedge clk) if (vout_a) vcount_a <= vcount_a + 1;

  aes_round_iter #(.NR(10), .COLS(1)) u_a (
    .clk(clk), .rst(rst), .vin(vin_a), .rdy(rdy_a), .state_in(sin),
    .round_idx(ridx_a), .round_key(rk_a), .state_out(sout_a),
    .vout(vout_a), .busy(busy_a)
`ifdef AES_ROUND_ITER_ABORT_EN
    , .abort(abort_a)
`endif
  );

  aes_round_iter #(.NR(10), .COLS(4)) u_b (
    .clk(clk), .rst(rst), .vin(vin_b), .rdy(rdy_b), .state_in(sin),
    .round_idx(ridx_b), .round_key(rk_b), .state_out(sout_b),
    .vout(vout_b), .busy(busy_b)
`ifdef AES_ROUND_ITER_ABORT_EN
    , .abort(1'b0)
`endif
  );

  aes_round_iter #(.NR(14), .COLS(2)) u_c (
    .clk(clk), .rst(rst), .vin(vin_c), .rdy(rdy_c), .state_in(sin),
    .round_idx(ridx_c), .round_key(rk_c), .state_out(sout_c),
    .vout(vout_c), .busy(busy_c)
`ifdef AES_ROUND_ITER_ABORT_EN
    , .abort(1'b0)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Carry-less product reduced modulo 0x11B.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (a[i]) p = p ^ (15'(b) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return gm(a, 8'h02);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
  endfunction

  // Round key r of the expansion of a left-aligned key of nk words.
  function automatic logic [127:0] rk_of(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32 * i -: 32];
      end else begin
        t = w[i - 1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i - nk] ^ t;
      end
    end
    return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endfunction

  task automatic load_keys(input int sel, input logic [255:0] key, input int nk);
    logic [127:0] k;
    for (int r = 0; r < 16; r++) begin
      k = (r <= nk + 6) ? rk_of(key, nk, r) : '0;
      if (sel == 0) keys_a[r] = k;
      else if (sel == 1) keys_b[r] = k;
      else keys_c[r] = k;
    end
  endtask

  // Called at the negedge after the accept edge; returns that edge-distance
  // at which vout is first seen.
  task automatic wait_vout(output int n);
    n = 1;
    while (!s_vout && n < 70) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Starts in an IDLE cycle, ends one negedge after the vout cycle.
  task automatic run_block(input int sel, input logic [127:0] pt, input logic [127:0] ct,
                           input int lat, input string tag);
    int n;
    cur = sel;
    sin = pt;
    vin = 1'b1;
    check({tag, " rdy before"}, 128'(s_rdy), 128'(1));
    @(negedge clk);
    vin = 1'b0;
    check({tag, " busy"}, 128'(s_busy), 128'(1));
    wait_vout(n);
    check({tag, " latency"}, 128'(n), 128'(lat));
    @(negedge clk);
    check({tag, " ciphertext"}, s_sout, ct);
    check({tag, " rdy after"}, 128'(s_rdy), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int v0;
    logic [7:0] inv;
    logic [7:0] aff;
    logic [7:0] cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        aff[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^
                 inv[(b + 7) % 8] ^ cst[b];
      tb_sbox[x] = aff;
    end
    load_keys(0, {K1, 128'h0}, 4);
    load_keys(1, {KC1, 128'h0}, 4);
    load_keys(2, K3, 8);
    vin = 1'b0;
    sin = '0;
    cur = 0;
`ifdef AES_ROUND_ITER_ABORT_EN
    abort_a = 1'b0;
`endif

    // Reset values
    repeat (3) @(negedge clk);
    check("reset rdy", 128'(rdy_a), 128'(1));
    check("reset busy", 128'(busy_a), 128'(0));
    check("reset vout", 128'(vout_a), 128'(0));
    check("reset round_idx", 128'(ridx_a), 128'(0));
    check("reset state_out", sout_a, 128'h0);

    // First block on the first edge after reset release
    rst = 1'b0;
    run_block(0, P1, C1, 41, "fips128 cols1");
    run_block(1, PC, CC1, 11, "aes128 cols4");
    run_block(2, PC, CC3, 29, "aes256 cols2");

    // Back-to-back with vin held high; PC is presented while busy
    cur = 0;
    sin = P1;
    vin = 1'b1;
    @(negedge clk);
    sin = PC;
    check("b2b first busy", 128'(busy_a), 128'(1));
    wait_vout(n);
    check("b2b first latency", 128'(n), 128'(41));
    check("b2b rdy low at vout", 128'(rdy_a), 128'(0));
    load_keys(0, {KC1, 128'h0}, 4);
    @(negedge clk);
    check("b2b first ciphertext", sout_a, C1);
    check("b2b rdy after vout", 128'(rdy_a), 128'(1));
    @(negedge clk);
    vin = 1'b0;
    check("b2b second accepted", 128'(busy_a), 128'(1));
    wait_vout(n);
    check("b2b second latency", 128'(n), 128'(41));
    @(negedge clk);
    check("b2b second ciphertext", sout_a, CC1);

    // Reset in the middle of a block
    sin = P1;
    vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset rdy", 128'(rdy_a), 128'(1));
    check("midreset busy", 128'(busy_a), 128'(0));
    check("midreset vout", 128'(vout_a), 128'(0));
    check("midreset round_idx", 128'(ridx_a), 128'(0));
    check("midreset state_out", sout_a, 128'h0);
    v0 = vcount_a;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    #1;
    check("midreset no vout", 128'(vcount_a), 128'(v0));
    run_block(0, PC, CC1, 41, "post-reset");

`ifdef AES_ROUND_ITER_ABORT_EN
    // Abort at round 5 keeps the previous ciphertext
    sin = P1;
    vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    n = 0;
    while (ridx_a != 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort reached round 5", 128'(ridx_a), 128'(5));
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("abort rdy", 128'(rdy_a), 128'(1));
    check("abort busy", 128'(busy_a), 128'(0));
    check("abort state_out kept", sout_a, CC1);
    v0 = vcount_a;
    repeat (50) @(negedge clk);
    #1;
    check("abort no vout", 128'(vcount_a), 128'(v0));
    // Abort in IDLE is ignored and a simultaneous vin is accepted
    abort_a = 1'b1;
    sin = PC;
    vin = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    vin = 1'b0;
    check("idle abort accepted", 128'(busy_a), 128'(1));
    wait_vout(n);
    check("idle abort latency", 128'(n), 128'(41));
    @(negedge clk);
    check("idle abort ciphertext", sout_a, CC1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
